led_pattern_sequencer: RTL

//  Sequences the 8 green LEDs through selectable blink patterns at a programmable rate.
//  Two push-buttons step the pattern mode and the speed.

---
 rtl/led_seq_pkg.sv | 48 ++++
 rtl/key_debounce.sv | 51 +++++
 rtl/tick_prescaler.sv | 48 ++++
 rtl/led_pattern_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode codes, per-mode
// LED seeds, speed limit and the mode-step helpers.
package led_seq_pkg;

   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_BLINK = 2'd1;
   localparam logic [1:0] MODE_CHASE = 2'd2;
   localparam logic [1:0] MODE_FILL  = 2'd3;

   localparam logic [7:0] SEED_IDLE  = 8'h00;
   localparam logic [7:0] SEED_BLINK = 8'h00;
   localparam logic [7:0] SEED_CHASE = 8'h01;
   localparam logic [7:0] SEED_FILL  = 8'h00;

   localparam logic [1:0] SPEED_MAX = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = MODE_IDLE,
      ST_BLINK = MODE_BLINK,
      ST_CHASE = MODE_CHASE,
      ST_FILL  = MODE_FILL
   } mode_e;

   function automatic mode_e mode_next(input mode_e m);
      mode_e n;
      n = ST_IDLE;
      case (m)
         ST_IDLE:  n = ST_BLINK;
         ST_BLINK: n = ST_CHASE;
         ST_CHASE: n = ST_FILL;
         default:  n = ST_IDLE;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] mode_seed(input mode_e m);
      logic [7:0] s;
      s = SEED_IDLE;
      case (m)
         ST_BLINK: s = SEED_BLINK;
         ST_CHASE: s = SEED_CHASE;
         ST_FILL:  s = SEED_FILL;
         default:  s = SEED_IDLE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchronizer, level debouncer and a
// single-cycle press pulse. Releases are debounced but produce no pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          stable_q;
   logic [CW-1:0] cnt_q;

   // bring the asynchronous key into the clock domain; reset reads as released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= key_n;
         sync_q2 <= sync_q1;
      end
   end

   // accept a new level after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press    <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_q2 == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync_q2;
            cnt_q    <= '0;
            press    <= ~sync_q2;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tick_prescaler.sv
// Pattern step prescaler: counts 0..P-1 with P = CLK_HZ/(TICK_HZ<<speed)
// and raises tick while the count sits at P-1. clear restarts the period,
// hold freezes the count and suppresses the tick.
module tick_prescaler #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] speed,
   input  logic       clear,
   input  logic       hold,
   output logic       tick
);

   localparam int CW = $clog2(CLK_HZ / TICK_HZ);
   localparam logic [CW-1:0] LAST0 = CW'(CLK_HZ / TICK_HZ - 1);
   localparam logic [CW-1:0] LAST1 = CW'(CLK_HZ / (TICK_HZ * 2) - 1);
   localparam logic [CW-1:0] LAST2 = CW'(CLK_HZ / (TICK_HZ * 4) - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] last;

   // terminal count for the selected speed; code 3 never occurs
   always_comb begin
      last = LAST0;
      case (speed)
         2'd1:    last = LAST1;
         2'd2:    last = LAST2;
         default: last = LAST0;
      endcase
   end

   assign tick = (cnt_q == last) && !hold;

   // free-running period counter with restart and freeze
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (!hold) begin
         if (cnt_q == last) cnt_q <= '0;
         else               cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: two keys step the pattern mode and the speed,
// LEDG walks the selected pattern once per prescaler tick.
// Optional build macro LED_SEQ_PAUSE_EN adds PAUSE_BTN_N and a pause flag.
//
//   state    | meaning
//   ST_IDLE  | LEDs dark, ticks ignored
//   ST_BLINK | all LEDs invert on each tick
//   ST_CHASE | single lit LED rotates left on each tick
//   ST_FILL  | LEDs fill from bit 0 upward, then clear (9-step cycle)
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int TICK_HZ         = 2,
   parameter int NUM_LEDS        = 8,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic                MODE_BTN_N,
   input  logic                SPEED_BTN_N,
`ifdef LED_SEQ_PAUSE_EN
   input  logic                PAUSE_BTN_N,
`endif
   output logic [NUM_LEDS-1:0] LEDG,
   output logic [1:0]          MODE
);

   logic                mode_pulse;
   logic                speed_pulse;
   logic                tick;
   logic                hold;
   logic [1:0]          speed_q;
   mode_e               state_q;
   mode_e               state_d;
   logic [NUM_LEDS-1:0] led_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key_n (MODE_BTN_N),
      .press (mode_pulse)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key_n (SPEED_BTN_N),
      .press (speed_pulse)
   );

`ifdef LED_SEQ_PAUSE_EN
   logic pause_pulse;
   logic pause_q;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key_n (PAUSE_BTN_N),
      .press (pause_pulse)
   );

   // pause toggles per press; stepping the mode always resumes
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N)         pause_q <= 1'b0;
      else if (mode_pulse)  pause_q <= 1'b0;
      else if (pause_pulse) pause_q <= ~pause_q;
   end

   assign hold = pause_q;
`else
   assign hold = 1'b0;
`endif

   tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .speed (speed_q),
      .clear (mode_pulse | speed_pulse),
      .hold  (hold),
      .tick  (tick)
   );

   // speed steps 0,1,2 and wraps back to 0
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         speed_q <= 2'd0;
      end else if (speed_pulse) begin
         if (speed_q >= SPEED_MAX) speed_q <= 2'd0;
         else                      speed_q <= speed_q + 2'd1;
      end
   end

   // next mode and LED pattern; a mode step wins over a coincident tick
   always_comb begin
      state_d = state_q;
      led_d   = LEDG;
      if (mode_pulse) begin
         state_d = mode_next(state_q);
         led_d   = NUM_LEDS'(mode_seed(state_d));
      end else if (tick) begin
         case (state_q)
            ST_IDLE:  led_d = '0;
            ST_BLINK: led_d = ~LEDG;
            ST_CHASE: led_d = {LEDG[NUM_LEDS-2:0], LEDG[NUM_LEDS-1]};
            ST_FILL:  led_d = (&LEDG) ? '0 : {LEDG[NUM_LEDS-2:0], 1'b1};
            default:  led_d = LEDG;
         endcase
      end
   end

   // mode state and LED pattern registers
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         LEDG    <= '0;
      end else begin
         state_q <= state_d;
         LEDG    <= led_d;
      end
   end

   assign MODE = state_q;

endmodule
